// File: rtl/ttc_int_pkg8.sv
// Shared constants for the timer interrupt collector: source count, counter width,
// APB register byte offsets and the fixed-priority source encoder.
package ttc_int_pkg8;
  localparam int NUM_SRC = 3;
  localparam int CNT_W   = 8;

  localparam logic [7:0] OFF_RAW  = 8'h00;
  localparam logic [7:0] OFF_PEND = 8'h04;
  localparam logic [7:0] OFF_IEN  = 8'h08;
  localparam logic [7:0] OFF_STAT = 8'h0C;
  localparam logic [7:0] OFF_CNT  = 8'h10;
  localparam logic [7:0] OFF_ID   = 8'h14;

  // Source 1 (bit 0) has the highest priority; 0 means nothing active.
  function automatic logic [1:0] prio_id(input logic [NUM_SRC-1:0] act);
    prio_id = 2'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (act[i]) prio_id = 2'(i + 1);
    end
  endfunction
endpackage

// File: rtl/ttc_int_src8.sv
// One timer interrupt source: rising-edge detect, sticky pending bit and saturating event counter.
// Pending and count update one edge after the input rises; the source never stalls.
module ttc_int_src8
  import ttc_int_pkg8::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lvl,
  input  logic             pend_clr,
  input  logic             cnt_clr,
  output logic             pend,
  output logic [CNT_W-1:0] cnt
);
  logic prev;
  logic rise;

  assign rise = lvl & ~prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev <= 1'b0;
      pend <= 1'b0;
      cnt  <= '0;
    end else begin
      prev <= lvl;
      // A new edge outranks a same-cycle software clear so no event is lost.
      if (rise)          pend <= 1'b1;
      else if (pend_clr) pend <= 1'b0;

      if (cnt_clr)                   cnt <= rise ? CNT_W'(1) : '0;
      else if (rise && (cnt != '1))  cnt <= cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/ttc_int_ctrl8.sv
// Timer interrupt collector: APB register file, per-source edge capture, masked priority request.
// irq8/irq_id8 are registered one edge after pending/enable state; APB is zero-wait, no backpressure.
module ttc_int_ctrl8
  import ttc_int_pkg8::*;
(
  input  logic        pclk8,
  input  logic        n_p_reset8,
  input  logic        psel8,
  input  logic        penable8,
  input  logic        pwrite8,
  input  logic [7:0]  paddr8,
  input  logic [31:0] pwdata8,
  output logic [31:0] prdata8,
  input  logic [3:1]  ttc_int8,
  output logic        irq8,
  output logic [1:0]  irq_id8
);
  logic                 wr_en;
  logic                 rd_en;
  logic [7:0]           word_addr;
  logic                 cnt_clr;
  logic [NUM_SRC-1:0]   pend_clr;
  logic [NUM_SRC-1:0]   pend;
  logic [NUM_SRC-1:0]   ien;
  logic [NUM_SRC-1:0]   active;
  logic [CNT_W-1:0]     cnt [NUM_SRC];
  logic                 unused_bits;

  assign wr_en     = psel8 & penable8 & pwrite8;
  assign rd_en     = psel8 & penable8 & ~pwrite8;
  assign word_addr = {paddr8[7:2], 2'b00};
  assign cnt_clr   = wr_en && (word_addr == OFF_CNT);
  assign pend_clr  = (wr_en && (word_addr == OFF_PEND)) ? pwdata8[NUM_SRC-1:0] : '0;
  assign active    = pend & ien;
  assign unused_bits = ^{pwdata8[31:NUM_SRC], paddr8[1:0]};

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    ttc_int_src8 u_src (
      .clk      (pclk8),
      .rst_n    (n_p_reset8),
      .lvl      (ttc_int8[i+1]),
      .pend_clr (pend_clr[i]),
      .cnt_clr  (cnt_clr),
      .pend     (pend[i]),
      .cnt      (cnt[i])
    );
  end

  always_ff @(posedge pclk8) begin
    if (!n_p_reset8) begin
      ien     <= '0;
      irq8    <= 1'b0;
      irq_id8 <= 2'd0;
    end else begin
      if (wr_en && (word_addr == OFF_IEN)) ien <= pwdata8[NUM_SRC-1:0];
      irq8    <= |active;
      irq_id8 <= prio_id(active);
    end
  end

  always_comb begin
    prdata8 = 32'd0;
    if (rd_en) begin
      case (word_addr)
        OFF_RAW:  prdata8[NUM_SRC-1:0] = ttc_int8;
        OFF_PEND: prdata8[NUM_SRC-1:0] = pend;
        OFF_IEN:  prdata8[NUM_SRC-1:0] = ien;
        OFF_STAT: prdata8[NUM_SRC-1:0] = active;
        OFF_CNT:  prdata8 = {8'h00, cnt[2], cnt[1], cnt[0]};
        OFF_ID:   prdata8[1:0] = irq_id8;
        default:  prdata8 = 32'd0;
      endcase
    end
  end
endmodule

// File: tb/tb_ttc_int_ctrl8.sv
// Randomized and directed stimulus against a behavioural model; reads are scoreboarded,
// irq8/irq_id8 are compared against the model every cycle.
module tb_ttc_int_ctrl8;
  logic        pclk8 = 1'b0;
  logic        n_p_reset8 = 1'b0;
  logic        psel8 = 1'b0;
  logic        penable8 = 1'b0;
  logic        pwrite8 = 1'b0;
  logic [7:0]  paddr8 = 8'h00;
  logic [31:0] pwdata8 = 32'h0;
  logic [31:0] prdata8;
  logic [3:1]  ttc_int8 = 3'b000;
  logic        irq8;
  logic [1:0]  irq_id8;

  int n_checks = 0;
  int n_fail   = 0;
  bit armed    = 1'b0;

  always #5 pclk8 = ~pclk8;

  ttc_int_ctrl8 dut (
    .pclk8      (pclk8),
    .n_p_reset8 (n_p_reset8),
    .psel8      (psel8),
    .penable8   (penable8),
    .pwrite8    (pwrite8),
    .paddr8     (paddr8),
    .pwdata8    (pwdata8),
    .prdata8    (prdata8),
    .ttc_int8   (ttc_int8),
    .irq8       (irq8),
    .irq_id8    (irq_id8)
  );

  // Reference model state: source n lives at index n-1.
  bit m_pend [3];
  bit m_ien  [3];
  bit m_prev [3];
  int m_cnt  [3];
  bit m_irq;
  int m_id;
  logic [31:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge pclk8) begin
    bit wr;
    int off;
    bit rise;
    if (!n_p_reset8) begin
      armed = 1'b1;
      for (int n = 0; n < 3; n++) begin
        m_pend[n] = 0; m_ien[n] = 0; m_prev[n] = 0; m_cnt[n] = 0;
      end
      m_irq = 0;
      m_id  = 0;
    end else begin
      m_id = 0;
      for (int n = 2; n >= 0; n--) if (m_pend[n] && m_ien[n]) m_id = n + 1;
      m_irq = (m_id != 0);
      wr  = psel8 && penable8 && pwrite8;
      off = int'(paddr8) / 4 * 4;
      for (int n = 0; n < 3; n++) begin
        rise = ttc_int8[n+1] && !m_prev[n];
        if (rise) m_pend[n] = 1;
        else if (wr && off == 'h04 && pwdata8[n]) m_pend[n] = 0;
        if (wr && off == 'h10) m_cnt[n] = rise ? 1 : 0;
        else if (rise) m_cnt[n] = (m_cnt[n] + 1 > 255) ? 255 : m_cnt[n] + 1;
        m_prev[n] = ttc_int8[n+1];
      end
      if (wr && off == 'h08) for (int n = 0; n < 3; n++) m_ien[n] = pwdata8[n];
    end
  end

  function automatic logic [31:0] model_read(input logic [7:0] a);
    logic [31:0] r;
    r = 32'h0;
    case (int'(a) / 4 * 4)
      'h00: r[2:0] = ttc_int8;
      'h04: for (int n = 0; n < 3; n++) r[n] = m_pend[n];
      'h08: for (int n = 0; n < 3; n++) r[n] = m_ien[n];
      'h0C: for (int n = 0; n < 3; n++) r[n] = m_pend[n] & m_ien[n];
      'h10: r = m_cnt[0] + (m_cnt[1] << 8) + (m_cnt[2] << 16);
      'h14: r = m_id;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // Monitor: pops an expected read value whenever the DUT presents read data.
  always @(negedge pclk8) begin
    if (armed) begin
      check("irq8", {31'h0, irq8}, {31'h0, m_irq});
      check("irq_id8", {30'h0, irq_id8}, m_id);
      if (psel8 && penable8 && !pwrite8) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rd_unexpected: got read at %h expected none queued", paddr8);
        end else begin
          check($sformatf("rd_%02h", paddr8), prdata8, exp_q.pop_front());
        end
      end else begin
        check("prdata_idle", prdata8, 32'h0);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish within bound");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge pclk8);
    #1;
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d, input logic [3:1] lv_acc);
    psel8 = 1; pwrite8 = 1; paddr8 = a; pwdata8 = d; penable8 = 0;
    tick();
    penable8 = 1;
    ttc_int8 = lv_acc;
    tick();
    psel8 = 0; penable8 = 0; pwrite8 = 0;
  endtask

  task automatic apb_read(input logic [7:0] a);
    psel8 = 1; pwrite8 = 0; paddr8 = a; penable8 = 0;
    tick();
    penable8 = 1;
    exp_q.push_back(model_read(a));
    tick();
    psel8 = 0; penable8 = 0;
  endtask

  task automatic pulse(input int n);
    ttc_int8[n] = 1'b1;
    tick();
    ttc_int8[n] = 1'b0;
    tick();
  endtask

  logic [7:0] addrs [8] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'hFD};

  initial begin
    n_p_reset8 = 0;
    repeat (3) tick();
    n_p_reset8 = 1;
    tick();
    check("rst_irq8", {31'h0, irq8}, 32'h0);
    check("rst_irq_id8", {30'h0, irq_id8}, 32'h0);
    for (int i = 0; i < 8; i++) apb_read(addrs[i]);

    // Basic request on source 2.
    apb_write(8'h08, 32'h7, ttc_int8);
    pulse(2);
    check("basic_irq8", {31'h0, irq8}, 32'h1);
    check("basic_id", {30'h0, irq_id8}, 32'h2);
    apb_read(8'h04);
    apb_write(8'h04, 32'h2, ttc_int8);
    tick();
    check("basic_clr_irq8", {31'h0, irq8}, 32'h0);

    // Priority and masking.
    pulse(3);
    pulse(2);
    check("prio_id2", {30'h0, irq_id8}, 32'h2);
    apb_write(8'h08, 32'h4, ttc_int8);
    apb_read(8'h0C);
    check("prio_id3", {30'h0, irq_id8}, 32'h3);
    apb_write(8'h08, 32'h0, ttc_int8);
    tick();
    check("mask_irq8", {31'h0, irq8}, 32'h0);
    apb_read(8'h04);

    // Set wins over a same-cycle clear.
    apb_write(8'h08, 32'h1, ttc_int8);
    pulse(1);
    tick();
    apb_write(8'h04, 32'h1, 3'b001);
    ttc_int8 = 3'b000;
    tick();
    check("collide_irq8", {31'h0, irq8}, 32'h1);
    apb_read(8'h04);

    // Counter saturation, clear-with-edge, held level.
    apb_write(8'h10, 32'h0, ttc_int8);
    for (int i = 0; i < 300; i++) pulse(1);
    apb_read(8'h10);
    apb_write(8'h10, 32'h0, 3'b001);
    repeat (5) tick();
    apb_read(8'h10);
    apb_read(8'h04);
    ttc_int8 = 3'b000;
    tick();

    // Randomized phase.
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 9))
        0, 1: pulse($urandom_range(1, 3));
        2: begin ttc_int8 = 3'($urandom); tick(); end
        3, 4: apb_write(addrs[$urandom_range(0, 7)], $urandom, 3'($urandom));
        5, 6, 7: apb_read(addrs[$urandom_range(0, 7)]);
        8: repeat ($urandom_range(1, 3)) tick();
        default: begin
          if ($urandom_range(0, 4) == 0) begin
            n_p_reset8 = 0;
            tick();
            n_p_reset8 = 1;
          end else begin
            apb_write(8'h08, 32'($urandom_range(0, 7)), ttc_int8);
          end
        end
      endcase
    end

    // Mid-operation reset with source 3 held high.
    ttc_int8 = 3'b000;
    apb_write(8'h08, 32'h7, ttc_int8);
    pulse(1);
    ttc_int8 = 3'b100;
    n_p_reset8 = 0;
    tick();
    check("mrst_irq8", {31'h0, irq8}, 32'h0);
    check("mrst_id", {30'h0, irq_id8}, 32'h0);
    n_p_reset8 = 1;
    tick();
    apb_read(8'h04);
    check("mrst_rel_irq8", {31'h0, irq8}, 32'h0);
    apb_read(8'h08);
    ttc_int8 = 3'b000;
    repeat (3) tick();

    check("queue_empty", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
